// File: rtl/demux_reg_32_if.sv
// Write-side handshake, freeze/commit status and the 32 register read-out buses
// of the staged register bank; master drives writes, slave is the bank.
interface demux_reg_32_if;
   logic        wr_valid;
   logic        wr_ready;
   logic [4:0]  wr_sel;
   logic [31:0] wr_data;
   logic        freeze;
   logic        wr_done;
   logic [4:0]  done_sel;
   logic        pend_valid;
   logic [31:0] out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7;
   logic [31:0] out8,  out9,  out10, out11, out12, out13, out14, out15;
   logic [31:0] out16, out17, out18, out19, out20, out21, out22, out23;
   logic [31:0] out24, out25, out26, out27, out28, out29, out30, out31;

   modport master (
      output wr_valid, wr_sel, wr_data, freeze,
      input  wr_ready, wr_done, done_sel, pend_valid,
      input  out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
      input  out8,  out9,  out10, out11, out12, out13, out14, out15,
      input  out16, out17, out18, out19, out20, out21, out22, out23,
      input  out24, out25, out26, out27, out28, out29, out30, out31
   );

   modport slave (
      input  wr_valid, wr_sel, wr_data, freeze,
      output wr_ready, wr_done, done_sel, pend_valid,
      output out0,  out1,  out2,  out3,  out4,  out5,  out6,  out7,
      output out8,  out9,  out10, out11, out12, out13, out14, out15,
      output out16, out17, out18, out19, out20, out21, out22, out23,
      output out24, out25, out26, out27, out28, out29, out30, out31
   );
endinterface

// File: rtl/demux_reg_32.sv
// 32x32 register bank behind one pending write stage: commit lands one edge after accept.
// wr_ready drops only while freeze holds a pending write; writes never bypass to outN.
module demux_reg_32 #(
   parameter bit ZERO_REG0 = 1'b1
) (
   input  logic          clock,
   input  logic          reset,
   demux_reg_32_if.slave bus
);
   logic [31:0] bank_q [32];
   logic [31:0] bank_d [32];

   logic        pend_valid_q, pend_valid_d;
   logic [4:0]  pend_sel_q,   pend_sel_d;
   logic [31:0] pend_data_q,  pend_data_d;
   logic        wr_done_q,    wr_done_d;
   logic [4:0]  done_sel_q,   done_sel_d;

   logic        accept;
   logic        commit;

   // A pending entry may be replaced in the same edge it commits, giving one write per cycle.
   assign bus.wr_ready = !pend_valid_q || !bus.freeze;
   assign accept       = bus.wr_valid && bus.wr_ready;
   assign commit       = pend_valid_q && !bus.freeze;

   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_sel_d   = pend_sel_q;
      pend_data_d  = pend_data_q;
      wr_done_d    = commit;
      done_sel_d   = commit ? pend_sel_q : done_sel_q;
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_sel_d   = bus.wr_sel;
         pend_data_d  = bus.wr_data;
      end else if (commit) begin
         pend_valid_d = 1'b0;
      end
   end

   always_comb begin
      for (int i = 0; i < 32; i++) begin
         bank_d[i] = bank_q[i];
      end
      // A hard-wired zero register swallows the data but still reports the commit.
      if (commit && !(ZERO_REG0 && (pend_sel_q == 5'd0))) begin
         bank_d[pend_sel_q] = pend_data_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            bank_q[i] <= 32'h0;
         end
         pend_valid_q <= 1'b0;
         pend_sel_q   <= 5'd0;
         pend_data_q  <= 32'h0;
         wr_done_q    <= 1'b0;
         done_sel_q   <= 5'd0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            bank_q[i] <= bank_d[i];
         end
         pend_valid_q <= pend_valid_d;
         pend_sel_q   <= pend_sel_d;
         pend_data_q  <= pend_data_d;
         wr_done_q    <= wr_done_d;
         done_sel_q   <= done_sel_d;
      end
   end

   assign bus.wr_done    = wr_done_q;
   assign bus.done_sel   = done_sel_q;
   assign bus.pend_valid = pend_valid_q;

   assign bus.out0  = ZERO_REG0 ? 32'h0 : bank_q[0];
   assign bus.out1  = bank_q[1];
   assign bus.out2  = bank_q[2];
   assign bus.out3  = bank_q[3];
   assign bus.out4  = bank_q[4];
   assign bus.out5  = bank_q[5];
   assign bus.out6  = bank_q[6];
   assign bus.out7  = bank_q[7];
   assign bus.out8  = bank_q[8];
   assign bus.out9  = bank_q[9];
   assign bus.out10 = bank_q[10];
   assign bus.out11 = bank_q[11];
   assign bus.out12 = bank_q[12];
   assign bus.out13 = bank_q[13];
   assign bus.out14 = bank_q[14];
   assign bus.out15 = bank_q[15];
   assign bus.out16 = bank_q[16];
   assign bus.out17 = bank_q[17];
   assign bus.out18 = bank_q[18];
   assign bus.out19 = bank_q[19];
   assign bus.out20 = bank_q[20];
   assign bus.out21 = bank_q[21];
   assign bus.out22 = bank_q[22];
   assign bus.out23 = bank_q[23];
   assign bus.out24 = bank_q[24];
   assign bus.out25 = bank_q[25];
   assign bus.out26 = bank_q[26];
   assign bus.out27 = bank_q[27];
   assign bus.out28 = bank_q[28];
   assign bus.out29 = bank_q[29];
   assign bus.out30 = bank_q[30];
   assign bus.out31 = bank_q[31];

   a_done_after_commit: assert property (@(posedge clock) disable iff (reset)
      commit |=> (bus.wr_done && (bus.done_sel == $past(pend_sel_q))));

   a_frozen_entry_holds: assert property (@(posedge clock) disable iff (reset)
      (pend_valid_q && bus.freeze) |=> (pend_valid_q && $stable(pend_sel_q) && $stable(pend_data_q)));
endmodule

// File: tb/tb_demux_reg_32.sv
// Directed vectors for the staged register bank, run on a zero-reg0 instance and a plain instance.
module tb_demux_reg_32;
   logic clock = 1'b0;
   logic reset = 1'b1;

   demux_reg_32_if bus0 ();
   demux_reg_32_if bus1 ();

   demux_reg_32 #(.ZERO_REG0(1'b1)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
   demux_reg_32 #(.ZERO_REG0(1'b0)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));

   assign bus1.wr_valid = bus0.wr_valid;
   assign bus1.wr_sel   = bus0.wr_sel;
   assign bus1.wr_data  = bus0.wr_data;
   assign bus1.freeze   = bus0.freeze;

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        rst, vld;
      logic [4:0]  sel;
      logic [31:0] data;
      logic        frz, chk;
      logic        rdy, done;
      logic [4:0]  dsel;
      logic        pend;
      int          idx;
      logic [31:0] out, out1;
   } vec_t;

   vec_t tbl [20];

   function automatic vec_t mk(input logic rst, vld, input logic [4:0] sel, input logic [31:0] data,
                               input logic frz, chk, rdy, done, input logic [4:0] dsel,
                               input logic pend, input int idx, input logic [31:0] out, out1);
      vec_t v;
      v.rst = rst; v.vld = vld; v.sel = sel; v.data = data; v.frz = frz; v.chk = chk;
      v.rdy = rdy; v.done = done; v.dsel = dsel; v.pend = pend; v.idx = idx; v.out = out; v.out1 = out1;
      return v;
   endfunction

   function automatic logic [31:0] rd0(input int n);
      case (n)
         0: return bus0.out0;   1: return bus0.out1;   2: return bus0.out2;   3: return bus0.out3;
         4: return bus0.out4;   5: return bus0.out5;   6: return bus0.out6;   7: return bus0.out7;
         8: return bus0.out8;   9: return bus0.out9;   10: return bus0.out10; 11: return bus0.out11;
         12: return bus0.out12; 13: return bus0.out13; 14: return bus0.out14; 15: return bus0.out15;
         16: return bus0.out16; 17: return bus0.out17; 18: return bus0.out18; 19: return bus0.out19;
         20: return bus0.out20; 21: return bus0.out21; 22: return bus0.out22; 23: return bus0.out23;
         24: return bus0.out24; 25: return bus0.out25; 26: return bus0.out26; 27: return bus0.out27;
         28: return bus0.out28; 29: return bus0.out29; 30: return bus0.out30; default: return bus0.out31;
      endcase
   endfunction

   function automatic logic [31:0] rd1(input int n);
      case (n)
         0: return bus1.out0;   1: return bus1.out1;   2: return bus1.out2;   3: return bus1.out3;
         4: return bus1.out4;   5: return bus1.out5;   6: return bus1.out6;   7: return bus1.out7;
         8: return bus1.out8;   9: return bus1.out9;   10: return bus1.out10; 11: return bus1.out11;
         12: return bus1.out12; 13: return bus1.out13; 14: return bus1.out14; 15: return bus1.out15;
         16: return bus1.out16; 17: return bus1.out17; 18: return bus1.out18; 19: return bus1.out19;
         20: return bus1.out20; 21: return bus1.out21; 22: return bus1.out22; 23: return bus1.out23;
         24: return bus1.out24; 25: return bus1.out25; 26: return bus1.out26; 27: return bus1.out27;
         28: return bus1.out28; 29: return bus1.out29; 30: return bus1.out30; default: return bus1.out31;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input logic r, v, input logic [4:0] s, input logic [31:0] d, input logic f);
      reset         = r;
      bus0.wr_valid = v;
      bus0.wr_sel   = s;
      bus0.wr_data  = d;
      bus0.freeze   = f;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_status(input string nm, input logic rdy, pend, done, input logic [4:0] dsel);
      chk({nm, " wr_ready"},   bus0.wr_ready,   rdy);
      chk({nm, " pend_valid"}, bus0.pend_valid, pend);
      chk({nm, " wr_done"},    bus0.wr_done,    done);
      chk({nm, " done_sel"},   bus0.done_sel,   dsel);
   endtask

   initial begin
      // reset (with a write offered), single write, freeze/hold, reg0, back-to-back same index
      tbl[0]  = mk(1,1,5,32'hCAFEF00D,0, 0, 1,0,0,0, 0,32'h0,32'h0);
      tbl[1]  = mk(0,1,5,32'hDEADBEEF,0, 1, 1,0,0,0, 5,32'h0,32'h0);
      tbl[2]  = mk(0,0,0,32'h0,0,        1, 1,0,0,1, 5,32'h0,32'h0);
      tbl[3]  = mk(0,0,0,32'h0,0,        1, 1,1,5,0, 5,32'hDEADBEEF,32'hDEADBEEF);
      tbl[4]  = mk(0,0,0,32'h0,0,        1, 1,0,5,0, 4,32'h0,32'h0);
      tbl[5]  = mk(0,1,7,32'h12345678,1, 1, 1,0,5,0, 7,32'h0,32'h0);
      tbl[6]  = mk(0,1,8,32'h88888888,1, 1, 0,0,5,1, 7,32'h0,32'h0);
      tbl[7]  = mk(0,1,8,32'h88888888,1, 1, 0,0,5,1, 7,32'h0,32'h0);
      tbl[8]  = mk(0,1,8,32'h88888888,0, 1, 1,0,5,1, 7,32'h0,32'h0);
      tbl[9]  = mk(0,0,0,32'h0,0,        1, 1,1,7,1, 7,32'h12345678,32'h12345678);
      tbl[10] = mk(0,0,0,32'h0,0,        1, 1,1,8,0, 8,32'h88888888,32'h88888888);
      tbl[11] = mk(0,0,3,32'h33333333,0, 1, 1,0,8,0, 7,32'h12345678,32'h12345678);
      tbl[12] = mk(0,1,0,32'hFFFFFFFF,0, 1, 1,0,8,0, 3,32'h0,32'h0);
      tbl[13] = mk(0,0,0,32'h0,0,        1, 1,0,8,1, 0,32'h0,32'h0);
      tbl[14] = mk(0,0,0,32'h0,0,        1, 1,1,0,0, 0,32'h0,32'hFFFFFFFF);
      tbl[15] = mk(0,1,9,32'hA1A1A1A1,0, 1, 1,0,0,0, 9,32'h0,32'h0);
      tbl[16] = mk(0,1,9,32'hB2B2B2B2,0, 1, 1,0,0,1, 9,32'h0,32'h0);
      tbl[17] = mk(0,0,0,32'h0,0,        1, 1,1,9,1, 9,32'hA1A1A1A1,32'hA1A1A1A1);
      tbl[18] = mk(0,0,0,32'h0,0,        1, 1,1,9,0, 9,32'hB2B2B2B2,32'hB2B2B2B2);
      tbl[19] = mk(0,0,0,32'h0,0,        1, 1,0,9,0, 0,32'h0,32'hFFFFFFFF);

      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].rst, tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].frz);
         @(negedge clock);
         if (tbl[i].chk) begin
            chk_status($sformatf("r%0d", i), tbl[i].rdy, tbl[i].pend, tbl[i].done, tbl[i].dsel);
            chk($sformatf("r%0d out%0d", i, tbl[i].idx), rd0(tbl[i].idx), tbl[i].out);
            chk($sformatf("r%0d plain out%0d", i, tbl[i].idx), rd1(tbl[i].idx), tbl[i].out1);
         end
         tick();
      end

      // streaming: one write per cycle, one wr_done per cycle two cycles behind
      for (int k = 1; k <= 31; k++) begin
         drive(0, 1, k[4:0], k * 32'h01010101, 0);
         @(negedge clock);
         chk_status($sformatf("stream%0d", k), 1'b1, k > 1, k > 2, (k > 2) ? 5'(k - 2) : 5'd9);
         tick();
      end
      drive(0, 0, 0, 32'h0, 0);
      @(negedge clock);
      chk_status("drain0", 1'b1, 1'b1, 1'b1, 5'd30);
      tick();
      @(negedge clock);
      chk_status("drain1", 1'b1, 1'b0, 1'b1, 5'd31);
      tick();
      @(negedge clock);
      chk_status("drain2", 1'b1, 1'b0, 1'b0, 5'd31);
      for (int n = 0; n < 32; n++) begin
         chk($sformatf("stream out%0d", n), rd0(n), (n == 0) ? 32'h0 : n * 32'h01010101);
      end
      chk("stream plain out0", rd1(0), 32'hFFFFFFFF);
      tick();

      // reset while a frozen write is pending discards it
      drive(0, 1, 3, 32'hAAAA5555, 1);
      @(negedge clock);
      chk_status("rstdrop accept", 1'b1, 1'b0, 1'b0, 5'd31);
      tick();
      drive(1, 0, 0, 32'h0, 1);
      @(negedge clock);
      chk_status("rstdrop held", 1'b0, 1'b1, 1'b0, 5'd31);
      chk("rstdrop held out3", rd0(3), 32'h03030303);
      tick();
      drive(0, 0, 0, 32'h0, 0);
      @(negedge clock);
      chk_status("rstdrop after", 1'b1, 1'b0, 1'b0, 5'd0);
      for (int n = 0; n < 32; n++) begin
         chk($sformatf("rstdrop out%0d", n), rd0(n), 32'h0);
      end
      chk("rstdrop plain out0", rd1(0), 32'h0);
      tick();
      @(negedge clock);
      chk_status("rstdrop quiet", 1'b1, 1'b0, 1'b0, 5'd0);
      chk("rstdrop quiet out3", rd0(3), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
